// File: rtl/slow_clk_period_meter_pkg.sv
// Shared types and default constants for the slow-clock period meter.
// Defaults assume a 100 MHz system clock watching a 1 Hz tick.
package slow_clk_period_meter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_MEAS = 2'd2
    } state_t;

    localparam int CLK_HZ         = 100_000_000;
    localparam int SIG_HZ         = 1;
    localparam int DEF_EXP_PERIOD = CLK_HZ / SIG_HZ;
    localparam int DEF_TOL        = DEF_EXP_PERIOD / 100;
    localparam int DEF_TIMEOUT    = DEF_EXP_PERIOD + DEF_EXP_PERIOD / 2;
    localparam int DEF_CNT_W      = 28;

endpackage

// File: rtl/slow_clk_period_meter_if.sv
// Control/result bundle of the period meter; master drives En/Sig_In,
// slave (the meter) returns the measurement.
interface slow_clk_period_meter_if #(
    parameter int CNT_W = 28
);
    logic             En;
    logic             Sig_In;
    logic [CNT_W-1:0] Period_Out;
    logic             Period_Valid;
    logic             In_Tol;
    logic             Timeout;
    logic             Busy;

    modport master (
        output En, Sig_In,
        input  Period_Out, Period_Valid, In_Tol, Timeout, Busy
    );

    modport slave (
        input  En, Sig_In,
        output Period_Out, Period_Valid, In_Tol, Timeout, Busy
    );
endinterface

// File: rtl/slow_clk_period_meter_sync_rise_detect.sv
// Two-flop synchronizer plus previous-value flop; rise is a one-cycle pulse
// with a fixed latency, so edge-to-edge spacing is preserved.
module sync_rise_detect (
    input  logic clk,
    input  logic rst,
    input  logic sig_in,
    output logic rise
);
    logic [1:0] sync_q, sync_d;
    logic       prev_q, prev_d;

    always_comb begin
        sync_d = {sync_q[0], sig_in};
        prev_d = sync_q[1];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign rise = sync_q[1] & ~prev_q;
endmodule

// File: rtl/slow_clk_period_meter.sv
// Measures rise-to-rise period of a slow asynchronous input in Clk_In cycles,
// flags tolerance against EXP_PERIOD and loss of signal.
module slow_clk_period_meter
    import slow_clk_period_meter_pkg::*;
#(
    parameter int EXP_PERIOD     = DEF_EXP_PERIOD,
    parameter int TOL            = DEF_TOL,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT,
    parameter int CNT_W          = DEF_CNT_W
) (
    input  logic                   Clk_In,
    input  logic                   Rst,
    slow_clk_period_meter_if.slave bus
);
    localparam logic [CNT_W-1:0] EXP_C = CNT_W'(EXP_PERIOD);
    localparam logic [CNT_W-1:0] TOL_C = CNT_W'(TOL);
    localparam logic [CNT_W-1:0] TMO_C = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] ONE_C = CNT_W'(1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic             in_tol_q, in_tol_d;
    logic             timeout_q, timeout_d;
    logic             valid_q, valid_d;
    logic [CNT_W-1:0] diff;
    logic             rise;

    sync_rise_detect u_sync (
        .clk    (Clk_In),
        .rst    (Rst),
        .sig_in (bus.Sig_In),
        .rise   (rise)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        period_d  = period_q;
        in_tol_d  = in_tol_q;
        timeout_d = timeout_q;
        valid_d   = 1'b0;
        diff      = (cnt_q >= EXP_C) ? (cnt_q - EXP_C) : (EXP_C - cnt_q);

        // Disable overrides everything, even a rise landing in the same cycle.
        if (!bus.En) begin
            state_d   = ST_IDLE;
            cnt_d     = '0;
            timeout_d = 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: state_d = ST_ARM;
                ST_ARM: begin
                    if (rise) begin
                        cnt_d     = ONE_C;
                        timeout_d = 1'b0;
                        state_d   = ST_MEAS;
                    end
                end
                ST_MEAS: begin
                    // A rise on the timeout cycle still completes the measurement.
                    if (rise) begin
                        period_d  = cnt_q;
                        in_tol_d  = (diff <= TOL_C);
                        valid_d   = 1'b1;
                        cnt_d     = ONE_C;
                        timeout_d = 1'b0;
                    end else if (cnt_q == TMO_C) begin
                        timeout_d = 1'b1;
                        cnt_d     = '0;
                        state_d   = ST_ARM;
                    end else begin
                        cnt_d = cnt_q + ONE_C;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge Clk_In or posedge Rst) begin
        if (Rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            period_q  <= '0;
            in_tol_q  <= 1'b0;
            timeout_q <= 1'b0;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            period_q  <= period_d;
            in_tol_q  <= in_tol_d;
            timeout_q <= timeout_d;
            valid_q   <= valid_d;
        end
    end

    assign bus.Period_Out   = period_q;
    assign bus.Period_Valid = valid_q;
    assign bus.In_Tol       = in_tol_q;
    assign bus.Timeout      = timeout_q;
    assign bus.Busy         = (state_q == ST_MEAS);
endmodule

// File: doc/slow_clk_period_meter.md
Name: slow_clk_period_meter

Overview:
- Receive-side counterpart of the fast-to-slow clock divider. Measures the period of a slow, asynchronous square-wave input (e.g. the 1 Hz tick) in Clk_In cycles.
- Flags whether the measured period is within tolerance of the expected value, and flags loss of the signal (timeout).
- Sits beside the traffic-light timing logic as a self-check/monitor of the slow clock.

Parameters:
- EXP_PERIOD, 100000000, expected rising-to-rising period in Clk_In cycles.
- TOL, 1000000, allowed absolute deviation from EXP_PERIOD in cycles (inclusive).
- TIMEOUT_CYCLES, 150000000, cycles with no rising edge before Timeout asserts; must exceed EXP_PERIOD+TOL.
- CNT_W, 28, counter/result width; must hold TIMEOUT_CYCLES.

Ports:
- Clk_In, input, 1, 100 MHz system clock.
- Rst, input, 1, asynchronous active-high reset.
- En, input, 1, measurement enable (synchronous to Clk_In).
- Sig_In, input, 1, slow signal under test (asynchronous to Clk_In).
- Period_Out, output, CNT_W, last measured period in cycles.
- Period_Valid, output, 1, one-cycle pulse when Period_Out/In_Tol update.
- In_Tol, output, 1, 1 when last Period_Out is within EXP_PERIOD±TOL.
- Timeout, output, 1, 1 when no rising edge within TIMEOUT_CYCLES.
- Busy, output, 1, 1 in MEAS state.

Behaviour:
- Reset: all outputs 0, counter 0, synchronizer and edge flops 0, state IDLE.
- Input path: 2-flop synchronizer, then a previous-value flop. A rise is seen when the sync value is 1 and the previous value is 0. Fixed 3-cycle latency, identical for every edge, so periods are unaffected. The synchronizer and previous-value flop run regardless of En. A Sig_In already high when En rises is not an edge.
- States:
  - IDLE: En=0. Counter held at 0, Timeout 0, Busy 0. Go to ARM when En=1.
  - ARM: wait for the first rise. On a rise: counter<=1, go to MEAS. No Period_Valid.
  - MEAS: Busy=1.
    - On a rise: Period_Out<=counter, Period_Valid=1 for one cycle, In_Tol<=(|counter−EXP_PERIOD|<=TOL), counter<=1, Timeout<=0, stay in MEAS.
    - With no rise: counter increments.
    - If counter==TIMEOUT_CYCLES and there is no rise: Timeout<=1, counter<=0, go to ARM.
- Period definition: rises in cycles t0 and t1 give Period_Out = t1−t0.
- Edge vs timeout in the same cycle: the edge wins; the measurement completes and Timeout is not set.
- Timeout stays set while in ARM. It clears on the next rise, which only re-arms (no Period_Valid).
- En=0 in any state: go to IDLE next cycle, counter 0, Timeout 0. No Period_Valid is generated, including for a rise in that same cycle. Period_Out and In_Tol hold their last values.
- Tolerance compare: unsigned, ordered subtraction (larger minus smaller) at CNT_W width, no wrap. Counter never exceeds TIMEOUT_CYCLES, so it never saturates or wraps.
- Rst mid-measurement: immediate return to reset values. The first period after reset requires two rises.

Decomposition:
- Shared package: state encoding (IDLE/ARM/MEAS) and default constants (100 MHz clock frequency, 1 Hz expected period, default TOL/TIMEOUT).
- Sub-module sync_rise_detect: 2-flop synchronizer plus rise pulse, with async active-high reset; reusable by other slow-input consumers.

Test Plan (sim params EXP_PERIOD=100, TOL=2, TIMEOUT_CYCLES=200, CNT_W=8):
- Square wave of period 100, En=1 → first rise gives no valid. Every later rise: Period_Valid pulses one cycle, Period_Out=100, In_Tol=1, Busy=1.
- Periods 103, then 98, then 102 → Period_Out=103/In_Tol=0, then 98/In_Tol=1, then 102/In_Tol=1.
- Sig_In held constant after a rise → Timeout=1 exactly 200 cycles after that rise's detection, no Period_Valid. Next rise: Timeout=0, no valid. Following rise at +100: Period_Out=100.
- Rise arriving on the exact cycle counter==200 → Period_Valid=1, Period_Out=200, In_Tol=0, Timeout stays 0.
- En deasserted mid-period, then reasserted while Sig_In is high → no Period_Valid. Period_Out keeps 100. Measurement restarts only at the next genuine rise, plus one full period.
- Rst pulsed asynchronously mid-MEAS → all outputs 0 immediately. After release, two rises are needed before Period_Valid.
